// File: rtl/fwd_net.sv
// Operand-forwarding network at the decode->execute boundary. It picks the youngest matching
// producer for each read port, flags load-use hazards, and holds forwarded values while stalled.
module fwd_net #(
  parameter int unsigned NR        = 2,
  parameter int unsigned NS        = 3,
  parameter int unsigned AW        = 5,
  parameter int unsigned DW        = 32,
  parameter bit          ZERO_SKIP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             stall_i,
  input  logic [NR*AW-1:0] rd_addr_i,
  input  logic [NS-1:0]    prod_we_i,
  input  logic [NS-1:0]    prod_rdy_i,
  input  logic [NS*AW-1:0] prod_waddr_i,
  input  logic [NS*DW-1:0] prod_wdata_i,
  output logic [NR-1:0]    fwd_sel_o,
  output logic [NR*DW-1:0] fwd_data_o,
  output logic [NR-1:0]    hazard_o,
  output logic             stall_req_o
);

  typedef enum logic {LIVE = 1'b0, HELD = 1'b1} state_e;

  logic [NR*AW-1:0] rd_addr_q;
  logic [NS-1:0]    prod_we_q;
  logic [NS-1:0]    prod_rdy_q;
  logic [NS*AW-1:0] prod_waddr_q;
  logic [NS*DW-1:0] prod_wdata_q;

  state_e           state_q [NR];
  state_e           state_d [NR];
  logic [DW-1:0]    hold_q  [NR];
  logic [DW-1:0]    hold_d  [NR];

  logic [AW-1:0]    addr_c  [NR];
  logic             hit_c   [NR];
  logic             rdy_c   [NR];
  logic [DW-1:0]    data_c  [NR];

  // Operand addresses freeze while the consumer is stalled; producers are always re-sampled.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_addr_q    <= '0;
      prod_we_q    <= '0;
      prod_rdy_q   <= '0;
      prod_waddr_q <= '0;
      prod_wdata_q <= '0;
    end else begin
      if (!stall_i) rd_addr_q <= rd_addr_i;
      prod_we_q    <= prod_we_i;
      prod_rdy_q   <= prod_rdy_i;
      prod_waddr_q <= prod_waddr_i;
      prod_wdata_q <= prod_wdata_i;
    end
  end

  // Per-port hold FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NR; p++) begin
        state_q[p] <= LIVE;
        hold_q[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < NR; p++) begin
        state_q[p] <= state_d[p];
        hold_q[p]  <= hold_d[p];
      end
    end
  end

  // The lowest-indexed matching producer wins, even if an older one already has data.
  always_comb begin
    fwd_sel_o  = '0;
    fwd_data_o = '0;
    hazard_o   = '0;
    for (int p = 0; p < NR; p++) begin
      state_d[p] = state_q[p];
      hold_d[p]  = hold_q[p];
      addr_c[p]  = rd_addr_q[p*AW +: AW];
      hit_c[p]   = 1'b0;
      rdy_c[p]   = 1'b0;
      data_c[p]  = '0;
      for (int s = 0; s < NS; s++) begin
        if (!hit_c[p] && prod_we_q[s] && (prod_waddr_q[s*AW +: AW] == addr_c[p]) &&
            !(ZERO_SKIP && (addr_c[p] == '0))) begin
          hit_c[p]  = 1'b1;
          rdy_c[p]  = prod_rdy_q[s];
          data_c[p] = prod_wdata_q[s*DW +: DW];
        end
      end

      case (state_q[p])
        LIVE: begin
          fwd_sel_o[p] = hit_c[p] && rdy_c[p];
          hazard_o[p]  = hit_c[p] && !rdy_c[p];
          if (hit_c[p] && rdy_c[p]) fwd_data_o[p*DW +: DW] = data_c[p];
          if (stall_i && hit_c[p] && rdy_c[p]) begin
            state_d[p] = HELD;
            hold_d[p]  = data_c[p];
          end
        end
        HELD: begin
          fwd_sel_o[p]            = 1'b1;
          fwd_data_o[p*DW +: DW] = hold_q[p];
          if (!stall_i) state_d[p] = LIVE;
        end
        default: state_d[p] = LIVE;
      endcase

      if (flush_i) begin
        state_d[p] = LIVE;
        hold_d[p]  = '0;
      end
    end
  end

  assign stall_req_o = |hazard_o;

endmodule

// File: tb/tb_fwd_net.sv
// Self-checking bench for fwd_net: expected outputs are queued as stimulus is driven and
// compared one cycle later, when the registered snapshot reaches the outputs.
module tb_fwd_net;
  localparam int unsigned NR = 2;
  localparam int unsigned NS = 3;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush_i;
  logic             stall_i;
  logic [NR*AW-1:0] rd_addr_i;
  logic [NS-1:0]    prod_we_i;
  logic [NS-1:0]    prod_rdy_i;
  logic [NS*AW-1:0] prod_waddr_i;
  logic [NS*DW-1:0] prod_wdata_i;
  logic [NR-1:0]    fwd_sel_o;
  logic [NR*DW-1:0] fwd_data_o;
  logic [NR-1:0]    hazard_o;
  logic             stall_req_o;

  fwd_net #(.NR(NR), .NS(NS), .AW(AW), .DW(DW), .ZERO_SKIP(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .stall_i      (stall_i),
    .rd_addr_i    (rd_addr_i),
    .prod_we_i    (prod_we_i),
    .prod_rdy_i   (prod_rdy_i),
    .prod_waddr_i (prod_waddr_i),
    .prod_wdata_i (prod_wdata_i),
    .fwd_sel_o    (fwd_sel_o),
    .fwd_data_o   (fwd_data_o),
    .hazard_o     (hazard_o),
    .stall_req_o  (stall_req_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  sel;
    logic [63:0] data;
    logic [1:0]  haz;
    logic        sreq;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr_i[p*AW +: AW] = a;
  endtask

  task automatic set_prod(input int s, input logic we, input logic rdy,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    prod_we_i[s]               = we;
    prod_rdy_i[s]              = rdy;
    prod_waddr_i[s*AW +: AW]   = a;
    prod_wdata_i[s*DW +: DW]   = d;
  endtask

  task automatic clr_prod();
    prod_we_i    = '0;
    prod_rdy_i   = '0;
    prod_waddr_i = '0;
    prod_wdata_i = '0;
  endtask

  // Push the expected outputs for the currently driven inputs, clock once, then pop and compare.
  task automatic step(input string tag, input logic [1:0] sel, input logic [63:0] data,
                      input logic [1:0] haz);
    exp_t e;
    exp_t o;
    string t;
    e.sel  = sel;
    e.data = data;
    e.haz  = haz;
    e.sreq = |haz;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    o = exp_q.pop_front();
    t = tag_q.pop_front();
    check_eq({t, ".sel"},  64'(fwd_sel_o),   64'(o.sel));
    check_eq({t, ".data"}, 64'(fwd_data_o),  o.data);
    check_eq({t, ".haz"},  64'(hazard_o),    64'(o.haz));
    check_eq({t, ".sreq"}, 64'(stall_req_o), 64'(o.sreq));
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; stall_i = 1'b0; rd_addr_i = '0;
    clr_prod();
    step("reset", 2'b00, 64'h0, 2'b00);
    rst = 1'b0;

    // Youngest producer wins; port 1 misses.
    set_rd(0, 5'd3); set_rd(1, 5'd4);
    set_prod(0, 1'b1, 1'b1, 5'd3, 32'hAAAA0001);
    set_prod(2, 1'b1, 1'b1, 5'd3, 32'h00000022);
    step("youngest", 2'b01, {32'h0, 32'hAAAA0001}, 2'b00);

    // Only the oldest producer matches.
    clr_prod();
    set_prod(2, 1'b1, 1'b1, 5'd3, 32'h00000022);
    step("oldest", 2'b01, {32'h0, 32'h00000022}, 2'b00);

    // Youngest match not ready blocks an older ready match.
    clr_prod();
    set_prod(0, 1'b1, 1'b0, 5'd3, 32'h11111111);
    set_prod(1, 1'b1, 1'b1, 5'd3, 32'h22222222);
    step("young_pend", 2'b00, 64'h0, 2'b01);

    // Register zero never forwards.
    clr_prod(); set_rd(0, 5'd0); set_rd(1, 5'd0);
    set_prod(0, 1'b1, 1'b1, 5'd0, 32'h55);
    step("zero_skip", 2'b00, 64'h0, 2'b00);

    // Load-use hazard resolves during a stall.
    clr_prod(); set_rd(1, 5'd7);
    set_prod(0, 1'b1, 1'b0, 5'd7, 32'h0);
    step("hazard", 2'b00, 64'h0, 2'b10);
    stall_i = 1'b1; clr_prod(); set_rd(1, 5'd2);
    set_prod(1, 1'b1, 1'b1, 5'd7, 32'h1234);
    step("hazard_res", 2'b10, {32'h1234, 32'h0}, 2'b00);
    stall_i = 1'b0; clr_prod(); set_rd(1, 5'd0);
    step("unstall", 2'b00, 64'h0, 2'b00);

    // Both ports hit one producer, then hold it through three stalled cycles.
    set_rd(0, 5'd5); set_rd(1, 5'd5);
    set_prod(1, 1'b1, 1'b1, 5'd5, 32'hDEAD);
    step("dual_hit", 2'b11, {32'hDEAD, 32'hDEAD}, 2'b00);
    stall_i = 1'b1; clr_prod(); set_rd(0, 5'd9); set_rd(1, 5'd9);
    step("held1", 2'b11, {32'hDEAD, 32'hDEAD}, 2'b00);
    step("held2", 2'b11, {32'hDEAD, 32'hDEAD}, 2'b00);
    set_prod(0, 1'b1, 1'b1, 5'd5, 32'h99);
    step("held3", 2'b11, {32'hDEAD, 32'hDEAD}, 2'b00);
    stall_i = 1'b0; clr_prod();
    set_prod(0, 1'b1, 1'b1, 5'd9, 32'h77);
    step("release", 2'b11, {32'h77, 32'h77}, 2'b00);

    // Flush beats stall while a port is held.
    clr_prod(); set_rd(0, 5'd5); set_rd(1, 5'd0);
    set_prod(1, 1'b1, 1'b1, 5'd5, 32'hDEAD);
    step("pre_flush", 2'b01, {32'h0, 32'hDEAD}, 2'b00);
    stall_i = 1'b1; clr_prod();
    step("held_f", 2'b01, {32'h0, 32'hDEAD}, 2'b00);
    flush_i = 1'b1;
    set_prod(0, 1'b1, 1'b1, 5'd5, 32'h42);
    step("flush", 2'b00, 64'h0, 2'b00);
    flush_i = 1'b0; clr_prod(); set_rd(0, 5'd6);
    step("post_flush", 2'b00, 64'h0, 2'b00);
    stall_i = 1'b0;

    // Synchronous reset mid-hazard.
    set_rd(0, 5'd8); set_rd(1, 5'd0);
    set_prod(2, 1'b1, 1'b0, 5'd8, 32'h0);
    step("pre_rst", 2'b00, 64'h0, 2'b01);
    rst = 1'b1;
    step("rst_haz", 2'b00, 64'h0, 2'b00);
    rst = 1'b0;
    step("after_rst", 2'b00, 64'h0, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
